// File: rtl/mole_board_fsm.sv
// Whack-a-mole board controller: lights one hole per round, scores hits and misses,
// and shortens the visible time after each hit down to a floor. Drives an external count-down timer.
module mole_board_fsm #(
   parameter logic [27:0] SHOW_TICKS = 28'd100_000_000,
   parameter logic [27:0] SHOW_STEP  = 28'd5_000_000,
   parameter logic [27:0] SHOW_MIN   = 28'd20_000_000,
   parameter logic [27:0] GAP_TICKS  = 28'd50_000_000,
   parameter logic [3:0]  MAX_MISSES = 4'd3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  btn,
   input  logic        time_trigger,
   output logic        timer_load,
   output logic [27:0] timer_loadval,
   output logic [7:0]  mole,
   output logic [7:0]  score,
   output logic [3:0]  misses,
   output logic        game_over
);

   typedef enum logic [2:0] {IDLE, ARM, SHOW, HIT, MISS, GAP, OVER} state_t;

   localparam logic [28:0] SHRINK_LIMIT = {1'b0, SHOW_MIN} + {1'b0, SHOW_STEP};

   state_t      state, next_state;
   logic        start_q, edge_armed;
   logic [7:0]  btn_q;
   logic [15:0] lfsr;
   logic [2:0]  prev_hole, hole_d, hole_pick;
   logic [27:0] cur_show, cur_show_d;
   logic [7:0]  score_d, mole_d;
   logic [3:0]  misses_d;
   logic        game_over_d, timer_load_d;
   logic [27:0] timer_loadval_d;
   logic        start_rise, hit_edge, wrong_edge, lfsr_fb;
   logic [7:0]  btn_rise;

   // Edges are qualified by edge_armed so a level already high when reset releases is not an event.
   assign start_rise = start & ~start_q & edge_armed;
   assign btn_rise   = btn & ~btn_q & {8{edge_armed}};
   assign hit_edge   = |(btn_rise & mole);
   assign wrong_edge = |(btn_rise & ~mole);
   assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign hole_pick  = (lfsr[2:0] == prev_hole) ? lfsr[2:0] + 3'd1 : lfsr[2:0];

   // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
   always_comb begin
      next_state = state;
      cur_show_d = cur_show;
      score_d    = score;
      misses_d   = misses;
      hole_d     = prev_hole;
      case (state)
         IDLE, OVER: begin
            if (start_rise) begin
               next_state = ARM;
               score_d    = 8'd0;
               misses_d   = 4'd0;
               cur_show_d = SHOW_TICKS;
            end
         end
         ARM: begin
            next_state = SHOW;
            hole_d     = hole_pick;
         end
         SHOW: begin
            if (hit_edge)                        next_state = HIT;
            else if (wrong_edge || time_trigger) next_state = MISS;
         end
         HIT: begin
            next_state = GAP;
            score_d    = (score == 8'hFF) ? score : score + 8'd1;
            cur_show_d = ({1'b0, cur_show} >= SHRINK_LIMIT) ? cur_show - SHOW_STEP : SHOW_MIN;
         end
         MISS: begin
            misses_d   = misses + 4'd1;
            next_state = (misses_d == MAX_MISSES) ? OVER : GAP;
         end
         GAP: begin
            // The trigger seen while the load is still on the port is left over from the last expiry.
            if (!timer_load && time_trigger) next_state = ARM;
         end
         default: next_state = IDLE;
      endcase
   end

   // Outputs are registered from next_state so each one lines up with the state it belongs to.
   always_comb begin
      timer_load_d    = 1'b0;
      timer_loadval_d = 28'd0;
      mole_d          = 8'd0;
      if (next_state == ARM) begin
         timer_load_d    = 1'b1;
         timer_loadval_d = cur_show_d;
      end else if (next_state == GAP && state != GAP) begin
         timer_load_d    = 1'b1;
         timer_loadval_d = GAP_TICKS;
      end
      if (state == ARM)                              mole_d = 8'd1 << hole_d;
      else if (state == SHOW && next_state == SHOW)  mole_d = mole;
      game_over_d = (next_state == OVER);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         start_q       <= 1'b0;
         btn_q         <= 8'd0;
         edge_armed    <= 1'b0;
         lfsr          <= 16'hACE1;
         prev_hole     <= 3'd0;
         cur_show      <= SHOW_TICKS;
         score         <= 8'd0;
         misses        <= 4'd0;
         game_over     <= 1'b0;
         mole          <= 8'd0;
         timer_load    <= 1'b0;
         timer_loadval <= 28'd0;
      end else begin
         state         <= next_state;
         start_q       <= start;
         btn_q         <= btn;
         edge_armed    <= 1'b1;
         lfsr          <= {lfsr[14:0], lfsr_fb};
         prev_hole     <= hole_d;
         cur_show      <= cur_show_d;
         score         <= score_d;
         misses        <= misses_d;
         game_over     <= game_over_d;
         mole          <= mole_d;
         timer_load    <= timer_load_d;
         timer_loadval <= timer_loadval_d;
      end
   end

endmodule

// File: tb/tb_mole_board_fsm.sv
// Directed bench for mole_board_fsm with a count-down timer model and a scoreboard of expected timer loads.
module tb_mole_board_fsm;

   localparam logic [27:0] ST = 28'd20;
   localparam logic [27:0] SS = 28'd5;
   localparam logic [27:0] SM = 28'd8;
   localparam logic [27:0] GT = 28'd4;
   localparam logic [3:0]  MM = 4'd3;

   logic        clk = 1'b0;
   logic        rst_n, start, time_trigger, timer_load, game_over;
   logic [7:0]  btn, mole, score;
   logic [3:0]  misses;
   logic [27:0] timer_loadval, tcnt;

   int checks = 0;
   int errors = 0;
   logic [27:0] exp_q[$];
   int model_show, exp_score, exp_misses;

   always #5 clk = ~clk;

   mole_board_fsm #(.SHOW_TICKS(ST), .SHOW_STEP(SS), .SHOW_MIN(SM), .GAP_TICKS(GT), .MAX_MISSES(MM)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .btn(btn), .time_trigger(time_trigger),
      .timer_load(timer_load), .timer_loadval(timer_loadval), .mole(mole),
      .score(score), .misses(misses), .game_over(game_over)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          tcnt <= 28'd0;
      else if (timer_load) tcnt <= timer_loadval;
      else if (tcnt != 0)  tcnt <= tcnt - 28'd1;
   end
   assign time_trigger = (tcnt == 28'd0);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic fail(input string tag);
      checks++;
      errors++;
      $error("FAIL %s", tag);
   endtask

   // Scoreboard consumer plus per-cycle invariants on mole and timer load.
   logic [7:0] last_lit, prev_mole;
   logic       prev_load;
   always @(negedge clk) begin
      if (!rst_n) begin
         last_lit  <= 8'd0;
         prev_mole <= 8'd0;
         prev_load <= 1'b0;
      end else begin
         if (timer_load) begin
            if (exp_q.size() == 0) fail("unexpected_timer_load");
            else check("timer_loadval", timer_loadval, exp_q.pop_front());
            check("mole_during_load", mole, 0);
            check("load_single_cycle", prev_load, 0);
         end else begin
            check("loadval_zero_when_idle", timer_loadval, 0);
         end
         if (mole != 8'd0) begin
            check("mole_onehot", $onehot(mole), 1);
            if (prev_mole == 8'd0) begin
               check("mole_not_repeated", (mole == last_lit), 0);
               last_lit <= mole;
            end
         end
         prev_mole <= mole;
         prev_load <= timer_load;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_show();
      int k = 0;
      while (mole == 8'd0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (mole == 8'd0) fail("show_timeout");
   endtask

   task automatic advance_show();
      int v = model_show - int'(SS);
      model_show = (v < int'(SM)) ? int'(SM) : v;
   endtask

   task automatic hit();
      wait_show();
      btn = mole;
      exp_score = (exp_score == 255) ? 255 : exp_score + 1;
      advance_show();
      exp_q.push_back(GT);
      exp_q.push_back(28'(model_show));
      tick(1);
      btn = 8'd0;
   endtask

   task automatic timeout_miss(output int len);
      wait_show();
      exp_misses++;
      if (exp_misses < int'(MM)) begin
         exp_q.push_back(GT);
         exp_q.push_back(28'(model_show));
      end
      len = 1;
      while (len < 100) begin
         @(negedge clk);
         if (mole == 8'd0) break;
         len++;
      end
   endtask

   task automatic new_game();
      start = 1'b1;
      model_show = int'(ST);
      exp_score  = 0;
      exp_misses = 0;
      exp_q.push_back(ST);
      tick(1);
   endtask

   initial begin
      int len, k;
      rst_n = 1'b0; start = 1'b0; btn = 8'd0;
      model_show = int'(ST); exp_score = 0; exp_misses = 0;
      #12;
      check("rst_mole", mole, 0);
      check("rst_score", score, 0);
      check("rst_misses", misses, 0);
      check("rst_game_over", game_over, 0);
      check("rst_timer_load", timer_load, 0);
      check("rst_timer_loadval", timer_loadval, 0);
      @(negedge clk) rst_n = 1'b1;
      tick(2);

      // First game: hit five cycles into SHOW, mole dark through HIT, GAP and ARM.
      new_game();
      start = 1'b0;
      check("start_game_over", game_over, 0);
      check("start_score", score, 0);
      wait_show();
      tick(4);
      btn = mole;
      exp_score = 1;
      advance_show();
      exp_q.push_back(GT);
      exp_q.push_back(28'(model_show));
      tick(1);
      btn = 8'd0;
      check("mole_dark_hit", mole, 0);
      for (int i = 0; i < 7; i++) begin
         tick(1);
         check("mole_dark_gap", mole, 0);
      end
      check("score_first_hit", score, 1);

      // Show time shrinks 15 -> 10 -> 8 -> 8.
      repeat (3) hit();
      tick(3);
      check("score_four_hits", score, 8'(exp_score));

      // Wrong hole alone is a miss.
      wait_show();
      btn = {mole[6:0], mole[7]};
      exp_misses = 1;
      exp_q.push_back(GT);
      exp_q.push_back(28'(model_show));
      tick(1);
      btn = 8'd0;
      tick(2);
      check("misses_wrong_hole", misses, 1);
      check("score_after_wrong", score, 8'(exp_score));

      // Correct hole in the same cycle as timer expiry wins.
      wait_show();
      k = 0;
      while (!time_trigger && k < 50) begin
         tick(1);
         k++;
      end
      if (!time_trigger) fail("trigger_timeout");
      check("mole_lit_at_trigger", (mole != 8'd0), 1);
      btn = mole;
      exp_score++;
      advance_show();
      exp_q.push_back(GT);
      exp_q.push_back(28'(model_show));
      tick(1);
      btn = 8'd0;
      tick(2);
      check("score_simultaneous", score, 8'(exp_score));
      check("misses_simultaneous", misses, 1);

      // Two timeouts finish the game at three misses.
      timeout_miss(len);
      check("show_len_floor", len, 9);
      tick(2);
      check("misses_second", misses, 2);
      timeout_miss(len);
      check("show_len_floor_last", len, 9);
      tick(2);
      check("over_game_over", game_over, 1);
      check("over_misses", misses, 3);
      check("over_mole", mole, 0);
      check("over_score_held", score, 8'(exp_score));

      // Restart from OVER and time out three times at full show time.
      new_game();
      start = 1'b0;
      check("restart_game_over", game_over, 0);
      check("restart_score", score, 0);
      check("restart_misses", misses, 0);
      timeout_miss(len);
      check("show_len_initial", len, 21);
      timeout_miss(len);
      timeout_miss(len);
      tick(2);
      check("over2_game_over", game_over, 1);
      check("over2_misses", misses, 3);
      check("over2_mole", mole, 0);

      // Reset mid-SHOW with start held through release.
      new_game();
      wait_show();
      tick(3);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_mole", mole, 0);
      check("async_rst_score", score, 0);
      check("async_rst_misses", misses, 0);
      check("async_rst_game_over", game_over, 0);
      check("async_rst_timer_load", timer_load, 0);
      check("async_rst_timer_loadval", timer_loadval, 0);
      exp_q.delete();
      @(negedge clk) rst_n = 1'b1;
      tick(10);
      check("held_start_mole", mole, 0);
      check("held_start_score", score, 0);
      start = 1'b0;
      tick(1);

      // Long run: saturating score and many rounds under the invariant monitor.
      new_game();
      start = 1'b0;
      repeat (260) hit();
      tick(3);
      check("score_saturated", score, 255);
      k = 0;
      while (exp_q.size() != 0 && k < 50) begin
         tick(1);
         k++;
      end
      check("scoreboard_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mole_board_fsm.md
MOLE_BOARD_FSM -- requirements
Module: mole_board_fsm

Interface
REQ-001 SHALL have parameter SHOW_TICKS, default 28'd100_000_000, initial mole-visible time in clk cycles.
REQ-002 SHALL have parameter SHOW_STEP, default 28'd5_000_000, show-time reduction per hit.
REQ-003 SHALL have parameter SHOW_MIN, default 28'd20_000_000, show-time floor.
REQ-004 SHALL have parameter GAP_TICKS, default 28'd50_000_000, blank time between moles.
REQ-005 SHALL have parameter MAX_MISSES, default 4'd3, misses that end the game.
REQ-006 SHALL have ports: clk  in  1  system clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: start  in  1  debounced start button, level; btn  in  8  debounced hole buttons, level.
REQ-008 SHALL have port: time_trigger  in  1  count-down timer expiry, registered, high while timer count is zero.
REQ-009 SHALL have ports: timer_load  out  1  one-cycle timer load pulse; timer_loadval  out  28  value loaded.
REQ-010 SHALL have ports: mole  out  8  one-hot lit hole, zero when none lit; score  out  8  hit count; misses  out  4  miss count; game_over  out  1  game-over flag.

Function
REQ-011 SHALL rising-edge detect start and each btn bit against a one-cycle-delayed copy; only edges are events.
REQ-012 SHALL implement states IDLE, ARM, SHOW, HIT, MISS, GAP, OVER.
REQ-013 IDLE: mole=0; start edge -> clear score, misses, cur_show=SHOW_TICKS; go ARM.
REQ-014 ARM (one cycle): timer_load=1, timer_loadval=cur_show, mole=new hole; go SHOW.
REQ-015 New hole index = lfsr[2:0]; if equal to previous hole index, use (index+1) mod 8.
REQ-016 LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 at reset, advances every cycle in all states.
REQ-017 SHOW: mole held; btn edge on lit hole -> HIT; btn edge on any other hole, or time_trigger=1 -> MISS.
REQ-018 SHOW simultaneous events: correct-hole edge wins over time_trigger and over wrong-hole edges in the same cycle.
REQ-019 HIT (one cycle): score+1 saturating at 255; cur_show = max(cur_show-SHOW_STEP, SHOW_MIN), no underflow; mole=0; go GAP.
REQ-020 MISS (one cycle): misses+1; mole=0; if new misses == MAX_MISSES go OVER, else GAP.
REQ-021 GAP: timer_load=1 on first GAP cycle only, timer_loadval=GAP_TICKS; mole=0; btn edges ignored; leave to ARM when time_trigger=1 on any cycle after the load cycle.
REQ-022 SHALL ignore time_trigger in the cycle timer_load is asserted (stale value from previous expiry).
REQ-023 OVER: game_over=1, mole=0, score/misses held; start edge -> same actions as REQ-013, game_over=0.
REQ-024 start edges SHALL be ignored in ARM, SHOW, HIT, MISS, GAP.
REQ-025 timer_loadval SHALL be 0 whenever timer_load=0.
REQ-026 All outputs SHALL be registered; mole changes on the clock edge entering/leaving SHOW.

Reset
REQ-027 On rst_n=0 (any state, including mid-SHOW): state=IDLE, mole=0, score=0, misses=0, game_over=0, timer_load=0, timer_loadval=0, cur_show=SHOW_TICKS, lfsr=16'hACE1, edge-detect registers=0.
REQ-028 Release of rst_n with start held high SHALL NOT start a game (edge register reset to 0 then loaded; a game starts only on a 0->1 transition sampled after reset).

Verification (parameters overridden: SHOW_TICKS=20, SHOW_STEP=5, SHOW_MIN=8, GAP_TICKS=4, MAX_MISSES=3; timer model attached)
REQ-029 Start edge, press lit hole 5 cycles into SHOW -> score=1, next ARM timer_loadval=15, mole=0 through GAP.
REQ-030 Start, never press -> MISS after 21 cycles of SHOW; third miss -> game_over=1, misses=3, mole=0.
REQ-031 Four consecutive hits -> loadvals 20,15,10,8, then 8 held; score=255 plus one hit -> score stays 255.
REQ-032 Correct-hole edge in same cycle as time_trigger=1 -> HIT, score increments, misses unchanged; wrong-hole edge alone -> MISS.
REQ-033 rst_n asserted mid-SHOW -> all outputs 0 asynchronously; start held through reset release -> remains IDLE until start toggles.
REQ-034 100 consecutive rounds -> mole always one-hot in SHOW, never same hole twice in a row, timer_load exactly one cycle per ARM/GAP entry.
